// File: rtl/argmax_pkg.sv
// Shared types and constants for the argmax classification stage.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ARITH_FLOAT = 0;
  localparam int ARITH_FIXED = 1;

  function automatic int index_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_gt_cmp.sv
// Combinational strict greater-than of two scores, either as IEEE-754
// single-precision bit patterns (sign-magnitude order) or as signed fixed point.
module argmax_gt_cmp
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ARITH_TYPE = ARITH_FLOAT
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_gt
);

  generate
    if (ARITH_TYPE == ARITH_FIXED) begin : g_fixed
      assign o_gt = $signed(i_a) > $signed(i_b);
    end else begin : g_float
      logic                  w_sa;
      logic                  w_sb;
      logic [DATA_WIDTH-2:0] w_ma;
      logic [DATA_WIDTH-2:0] w_mb;
      logic                  w_both_zero;

      assign w_sa        = i_a[DATA_WIDTH-1];
      assign w_sb        = i_b[DATA_WIDTH-1];
      assign w_ma        = i_a[DATA_WIDTH-2:0];
      assign w_mb        = i_b[DATA_WIDTH-2:0];
      assign w_both_zero = (w_ma == '0) && (w_mb == '0);

      // +0 and -0 are equal; otherwise negatives order by decreasing magnitude.
      always_comb begin
        o_gt = 1'b0;
        if (w_both_zero)    o_gt = 1'b0;
        else if (w_sa != w_sb) o_gt = ~w_sa;
        else if (!w_sa)     o_gt = (w_ma > w_mb);
        else                o_gt = (w_ma < w_mb);
      end
    end
  endgenerate

endmodule

// File: rtl/argmax_classifier.sv
// LeNet5 final stage: latches the FC scores and scans them one per cycle for the
// argmax. Define ARGMAX_TOP2_EN to also report the runner-up class.
module argmax_classifier
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10,
  parameter int ARITH_TYPE  = ARITH_FLOAT,
  parameter int INDEX_BITS  = index_bits(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_from_previous,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in,
  output logic                              end_to_previous,
  output logic                              busy,
  output logic [INDEX_BITS-1:0]             class_index,
  output logic [DATA_WIDTH-1:0]             max_value,
  output logic                              output_ready,
  output logic                              overrun
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [INDEX_BITS-1:0]             second_index,
  output logic [DATA_WIDTH-1:0]             second_value
`endif
);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_buf [NUM_CLASSES];
  logic [INDEX_BITS-1:0] r_cnt;
  logic [INDEX_BITS-1:0] r_best_idx;
  logic [DATA_WIDTH-1:0] r_best_val;

  logic [DATA_WIDTH-1:0] w_cand;
  logic                  w_repl;
  logic                  w_last;
  logic [INDEX_BITS-1:0] w_best_idx_nxt;
  logic [DATA_WIDTH-1:0] w_best_val_nxt;

  assign w_cand         = r_buf[r_cnt];
  assign w_last         = (r_cnt == INDEX_BITS'(NUM_CLASSES - 1));
  assign w_best_idx_nxt = w_repl ? r_cnt  : r_best_idx;
  assign w_best_val_nxt = w_repl ? w_cand : r_best_val;
  assign busy           = (r_state != IDLE);

  argmax_gt_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARITH_TYPE (ARITH_TYPE)
  ) u_gt_best (
    .i_a  (w_cand),
    .i_b  (r_best_val),
    .o_gt (w_repl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_best_idx      <= '0;
      r_best_val      <= '0;
      class_index     <= '0;
      max_value       <= '0;
      output_ready    <= 1'b0;
      end_to_previous <= 1'b0;
      overrun         <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) r_buf[k] <= '0;
    end else begin
      output_ready    <= 1'b0;
      end_to_previous <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_from_previous) begin
            for (int k = 0; k < NUM_CLASSES; k++)
              r_buf[k] <= scores_in[k*DATA_WIDTH +: DATA_WIDTH];
            r_best_idx <= '0;
            r_best_val <= scores_in[DATA_WIDTH-1:0];
            r_cnt      <= INDEX_BITS'(1);
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (start_from_previous) overrun <= 1'b1;
          r_best_idx <= w_best_idx_nxt;
          r_best_val <= w_best_val_nxt;
          r_cnt      <= r_cnt + 1'b1;
          // Results are registered on the final compare so they are valid with output_ready.
          if (w_last) begin
            class_index     <= w_best_idx_nxt;
            max_value       <= w_best_val_nxt;
            output_ready    <= 1'b1;
            end_to_previous <= 1'b1;
            r_state         <= DONE;
          end
        end
        DONE: begin
          if (start_from_previous) overrun <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARGMAX_TOP2_EN
  logic [INDEX_BITS-1:0] r_sec_idx;
  logic [DATA_WIDTH-1:0] r_sec_val;
  logic                  w_sec_gt;
  logic                  w_sec_take;
  logic [INDEX_BITS-1:0] w_sec_idx_nxt;
  logic [DATA_WIDTH-1:0] w_sec_val_nxt;

  argmax_gt_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARITH_TYPE (ARITH_TYPE)
  ) u_gt_second (
    .i_a  (w_cand),
    .i_b  (r_sec_val),
    .o_gt (w_sec_gt)
  );

  // The first candidate always seeds the runner-up unless it displaces the best.
  assign w_sec_take    = ~w_repl & ((r_cnt == INDEX_BITS'(1)) | w_sec_gt);
  assign w_sec_idx_nxt = w_repl ? r_best_idx : (w_sec_take ? r_cnt  : r_sec_idx);
  assign w_sec_val_nxt = w_repl ? r_best_val : (w_sec_take ? w_cand : r_sec_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec_idx    <= '0;
      r_sec_val    <= '0;
      second_index <= '0;
      second_value <= '0;
    end else if (r_state == SCAN) begin
      r_sec_idx <= w_sec_idx_nxt;
      r_sec_val <= w_sec_val_nxt;
      if (w_last) begin
        second_index <= w_sec_idx_nxt;
        second_value <= w_sec_val_nxt;
      end
    end
  end
`endif

endmodule
